// File: rtl/lcd_pkg.sv
// Shared constants, state type and helpers for the ST7789 fill controller.
package lcd_pkg;

   localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
   localparam logic [15:0] COLOR_RED   = 16'hF800;
   localparam logic [15:0] COLOR_GREEN = 16'h07E0;
   localparam logic [15:0] COLOR_BLUE  = 16'h001F;

   localparam logic [7:0] CMD_SLPOUT = 8'h11;
   localparam logic [7:0] CMD_COLMOD = 8'h3A;
   localparam logic [7:0] CMD_MADCTL = 8'h36;
   localparam logic [7:0] CMD_DISPON = 8'h29;
   localparam logic [7:0] CMD_CASET  = 8'h2A;
   localparam logic [7:0] CMD_RASET  = 8'h2B;
   localparam logic [7:0] CMD_RAMWR  = 8'h2C;

   localparam logic [7:0] ARG_COLMOD_565 = 8'h55;
   localparam logic [7:0] ARG_MADCTL_DEF = 8'h00;

   localparam int unsigned INIT_LEN = 5;
   localparam int unsigned WIN_LEN  = 5;
   localparam int unsigned IDX_W    = 3;

   typedef enum logic [3:0] {
      RST_LOW, RST_WAIT, SLPOUT, WAKE_WAIT, INIT,
      IDLE, CASET, RASET, RAMWR, PIXELS, DONE
   } lcd_state_t;

   // Byte idx of a window-set sequence: cmd, 0x00, 0x00, last[15:8], last[7:0].
   function automatic logic [7:0] win_byte(input logic [IDX_W-1:0] idx,
                                           input logic [15:0] last);
      logic [7:0] b;
      b = 8'h00;
      if (idx == IDX_W'(3)) b = last[15:8];
      if (idx == IDX_W'(4)) b = last[7:0];
      return b;
   endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational lookup of the panel init list: index -> {dc, byte}.
module lcd_init_rom
   import lcd_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   output logic             dc_o,
   output logic [7:0]       byte_o
);

   always_comb begin
      dc_o   = 1'b0;
      byte_o = 8'h00;
      case (idx_i)
         IDX_W'(0): byte_o = CMD_COLMOD;
         IDX_W'(1): begin dc_o = 1'b1; byte_o = ARG_COLMOD_565; end
         IDX_W'(2): byte_o = CMD_MADCTL;
         IDX_W'(3): begin dc_o = 1'b1; byte_o = ARG_MADCTL_DEF; end
         IDX_W'(4): byte_o = CMD_DISPON;
         default:   ;
      endcase
   end

endmodule

// File: rtl/lcd_fill_ctrl.sv
// ST7789 power-up sequencer and full-screen RGB565 filler feeding a byte serializer.
// Optional one-deep request queue: define LCD_FILL_QUEUE_EN.
module lcd_fill_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned H_RES       = 240,
   parameter int unsigned V_RES       = 240,
   parameter int unsigned RST_CYCLES  = 500000,
   parameter int unsigned WAKE_CYCLES = 6000000
) (
   input  logic        clk_50mhz,
   input  logic        rst_n,
   input  logic        fill_req,
   input  logic [15:0] fill_color,
   output logic        fill_busy,
   output logic        fill_done,
   output logic        init_done,
   output logic        lcd_rst,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_dc,
   input  logic        tx_ready
);

   localparam int unsigned NPIX    = H_RES * V_RES;
   localparam int unsigned PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int unsigned DLY_MAX = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
   localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
   localparam logic [15:0] H_LAST  = 16'(H_RES - 1);
   localparam logic [15:0] V_LAST  = 16'(V_RES - 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
   localparam logic [DLY_W-1:0] RST_END  = DLY_W'(RST_CYCLES - 1);
   localparam logic [DLY_W-1:0] WAKE_END = DLY_W'(WAKE_CYCLES - 1);

   lcd_state_t       state_q;
   logic [DLY_W-1:0] dly_q;
   logic [IDX_W-1:0] idx_q;
   logic [PIX_W-1:0] pix_q;
   logic             phase_q;
   logic [15:0]      color_q;
   logic             lcd_rst_q, tx_valid_q, tx_dc_q, init_done_q, fill_busy_q, fill_done_q;
   logic [7:0]       tx_data_q;

   logic             tx_fire_c, start_c, rom_dc_c;
   logic [15:0]      start_color_c;
   logic [IDX_W-1:0] rom_idx_c;
   logic [7:0]       rom_byte_c;

   assign tx_fire_c = tx_valid_q && tx_ready;
   // Points at the entry to load next: entry 0 while waking, idx+1 while sending.
   assign rom_idx_c = (state_q == INIT) ? idx_q + IDX_W'(1) : '0;

   lcd_init_rom u_init_rom (
      .idx_i  (rom_idx_c),
      .dc_o   (rom_dc_c),
      .byte_o (rom_byte_c)
   );

`ifdef LCD_FILL_QUEUE_EN
   logic        pend_q;
   logic [15:0] pend_color_q;

   assign start_c       = (state_q == IDLE) && (fill_req || pend_q);
   assign start_color_c = fill_req ? fill_color : pend_color_q;

   // Latest request seen outside IDLE wins.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         pend_q       <= 1'b0;
         pend_color_q <= '0;
      end else if (state_q != IDLE && fill_req) begin
         pend_q       <= 1'b1;
         pend_color_q <= fill_color;
      end else if (start_c) begin
         pend_q       <= 1'b0;
      end
   end
`else
   assign start_c       = (state_q == IDLE) && fill_req;
   assign start_color_c = fill_color;
`endif

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RST_LOW;
         dly_q       <= '0;
         idx_q       <= '0;
         pix_q       <= '0;
         phase_q     <= 1'b0;
         color_q     <= '0;
         lcd_rst_q   <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         tx_dc_q     <= 1'b0;
         init_done_q <= 1'b0;
         fill_busy_q <= 1'b0;
         fill_done_q <= 1'b0;
      end else begin
         case (state_q)
            RST_LOW: begin
               if (dly_q == RST_END) begin
                  dly_q     <= '0;
                  lcd_rst_q <= 1'b1;
                  state_q   <= RST_WAIT;
               end else begin
                  dly_q <= dly_q + DLY_W'(1);
               end
            end
            RST_WAIT: begin
               if (dly_q == RST_END) begin
                  dly_q      <= '0;
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= CMD_SLPOUT;
                  tx_dc_q    <= 1'b0;
                  state_q    <= SLPOUT;
               end else begin
                  dly_q <= dly_q + DLY_W'(1);
               end
            end
            SLPOUT: begin
               if (tx_fire_c) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= WAKE_WAIT;
               end
            end
            WAKE_WAIT: begin
               if (dly_q == WAKE_END) begin
                  dly_q      <= '0;
                  idx_q      <= '0;
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= rom_byte_c;
                  tx_dc_q    <= rom_dc_c;
                  state_q    <= INIT;
               end else begin
                  dly_q <= dly_q + DLY_W'(1);
               end
            end
            INIT: begin
               if (tx_fire_c) begin
                  if (idx_q == IDX_W'(INIT_LEN - 1)) begin
                     tx_valid_q  <= 1'b0;
                     init_done_q <= 1'b1;
                     state_q     <= IDLE;
                  end else begin
                     idx_q     <= idx_q + IDX_W'(1);
                     tx_data_q <= rom_byte_c;
                     tx_dc_q   <= rom_dc_c;
                  end
               end
            end
            IDLE: begin
               if (start_c) begin
                  color_q     <= start_color_c;
                  fill_busy_q <= 1'b1;
                  idx_q       <= '0;
                  tx_valid_q  <= 1'b1;
                  tx_data_q   <= CMD_CASET;
                  tx_dc_q     <= 1'b0;
                  state_q     <= CASET;
               end
            end
            CASET, RASET: begin
               if (tx_fire_c) begin
                  if (idx_q == IDX_W'(WIN_LEN - 1)) begin
                     idx_q     <= '0;
                     tx_data_q <= (state_q == CASET) ? CMD_RASET : CMD_RAMWR;
                     tx_dc_q   <= 1'b0;
                     state_q   <= (state_q == CASET) ? RASET : RAMWR;
                  end else begin
                     idx_q     <= idx_q + IDX_W'(1);
                     tx_data_q <= win_byte(idx_q + IDX_W'(1), (state_q == CASET) ? H_LAST : V_LAST);
                     tx_dc_q   <= 1'b1;
                  end
               end
            end
            RAMWR: begin
               if (tx_fire_c) begin
                  pix_q     <= '0;
                  phase_q   <= 1'b0;
                  tx_data_q <= color_q[15:8];
                  tx_dc_q   <= 1'b1;
                  state_q   <= PIXELS;
               end
            end
            PIXELS: begin
               if (tx_fire_c) begin
                  if (!phase_q) begin
                     phase_q   <= 1'b1;
                     tx_data_q <= color_q[7:0];
                  end else if (pix_q == PIX_LAST) begin
                     tx_valid_q  <= 1'b0;
                     fill_busy_q <= 1'b0;
                     fill_done_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     pix_q     <= pix_q + PIX_W'(1);
                     phase_q   <= 1'b0;
                     tx_data_q <= color_q[15:8];
                  end
               end
            end
            DONE: begin
               fill_done_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= RST_LOW;
         endcase
      end
   end

   assign lcd_rst   = lcd_rst_q;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign tx_dc     = tx_dc_q;
   assign init_done = init_done_q;
   assign fill_busy = fill_busy_q;
   assign fill_done = fill_done_q;

endmodule

// File: tb/tb_lcd_fill_ctrl.sv
// Directed/random bench for lcd_fill_ctrl with a byte-stream reference model.
module tb_lcd_fill_ctrl;
   import lcd_pkg::*;

   localparam int unsigned H = 4, V = 4, RST = 4, WAKE = 8;
   localparam int unsigned NBYTES = 11 + 2 * H * V;

   typedef logic [8:0] xfer_t;
   typedef xfer_t xq_t[$];

   logic        clk_50mhz = 1'b0;
   logic        rst_n = 1'b0;
   logic        fill_req = 1'b0;
   logic [15:0] fill_color = '0;
   logic        tx_ready = 1'b1;
   logic        fill_busy, fill_done, init_done, lcd_rst, tx_valid, tx_dc;
   logic [7:0]  tx_data;

   int   checks = 0, errors = 0;
   xq_t  got;
   int   gaps[$];
   int   idle_run = 0, done_cnt = 0, busy_bad = 0;
   bit   stall_prev = 0, rnd_ready = 0;
   logic [7:0] prev_data = '0;
   logic       prev_dc = 1'b0;

   lcd_fill_ctrl #(.H_RES(H), .V_RES(V), .RST_CYCLES(RST), .WAKE_CYCLES(WAKE)) dut (
      .clk_50mhz (clk_50mhz), .rst_n (rst_n), .fill_req (fill_req), .fill_color (fill_color),
      .fill_busy (fill_busy), .fill_done (fill_done), .init_done (init_done), .lcd_rst (lcd_rst),
      .tx_valid (tx_valid), .tx_data (tx_data), .tx_dc (tx_dc), .tx_ready (tx_ready)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, pick tx_ready for the coming edge, log transfers.
   task automatic cycle();
      @(negedge clk_50mhz);
      fill_req = 1'b0;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_prev)
         chk("hold_while_stalled", {23'd0, tx_valid, tx_dc, tx_data}, {23'd0, 1'b1, prev_dc, prev_data});
      if (fill_done) done_cnt++;
      if (tx_valid && tx_ready) begin
         got.push_back({tx_dc, tx_data});
         gaps.push_back(idle_run);
         idle_run = 0;
         if (init_done && !fill_busy) busy_bad++;
      end else if (!tx_valid) begin
         idle_run++;
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_dc    = tx_dc;
   endtask

   function automatic xq_t init_model();
      xq_t q;
      q.push_back({1'b0, 8'h11});
      q.push_back({1'b0, 8'h3A}); q.push_back({1'b1, 8'h55});
      q.push_back({1'b0, 8'h36}); q.push_back({1'b1, 8'h00});
      q.push_back({1'b0, 8'h29});
      return q;
   endfunction

   function automatic xq_t fill_model(input logic [15:0] col);
      xq_t q;
      q.push_back({1'b0, 8'h2A}); q.push_back(9'h100); q.push_back(9'h100);
      q.push_back({1'b1, 8'((H - 1) >> 8)}); q.push_back({1'b1, 8'((H - 1) % 256)});
      q.push_back({1'b0, 8'h2B}); q.push_back(9'h100); q.push_back(9'h100);
      q.push_back({1'b1, 8'((V - 1) >> 8)}); q.push_back({1'b1, 8'((V - 1) % 256)});
      q.push_back({1'b0, 8'h2C});
      for (int p = 0; p < int'(H * V); p++) begin
         q.push_back({1'b1, col[15:8]});
         q.push_back({1'b1, col[7:0]});
      end
      return q;
   endfunction

   task automatic check_stream(input string tag, input xq_t exp);
      int mism = -1;
      chk({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         if (mism < 0 && got[i] !== exp[i]) mism = i;
      chk({tag, "_first_bad_idx"}, mism, -1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_lcd_rst"}, lcd_rst, 0);
      chk({tag, "_tx_valid"}, tx_valid, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
      chk({tag, "_tx_dc"}, tx_dc, 0);
      chk({tag, "_init_done"}, init_done, 0);
      chk({tag, "_fill_busy"}, fill_busy, 0);
      chk({tag, "_fill_done"}, fill_done, 0);
   endtask

   // Called right after rst_n is released at a negedge.
   task automatic run_init(input bit inject);
      int n, sum;
      got.delete(); gaps.delete(); idle_run = 0; rnd_ready = 0;
      n = 0; while (!lcd_rst && n < 100) begin cycle(); n++; end
      chk("rst_low_cycles", n, RST);
      n = 0; while (!tx_valid && n < 100) begin cycle(); n++; end
      chk("rst_high_cycles", n, RST);
      n = 0;
      while (!init_done && n < 300) begin
         cycle(); n++;
         if (inject && n == 3) begin fill_req = 1'b1; fill_color = COLOR_GREEN; end
         if (inject && n == 6) begin fill_req = 1'b1; fill_color = COLOR_BLUE; end
      end
      chk("init_done_rise", init_done, 1);
      check_stream("init", init_model());
      chk("wake_gap", (gaps.size() > 1) ? gaps[1] : -1, WAKE);
      sum = 0;
      for (int i = 2; i < gaps.size(); i++) sum += gaps[i];
      chk("init_back_to_back", sum, 0);
      chk("busy_during_init", fill_busy, 0);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!fill_done && n < 3000) begin cycle(); n++; end
      chk({tag, "_done_seen"}, fill_done, 1);
   endtask

   task automatic run_fill(input logic [15:0] col, input bit rnd, input bit inject,
                           input logic [15:0] inj_col, input bit req_at_done);
      int  n;
      bit  injected = 0;
      chk("busy_before_req", fill_busy, 0);
      got.delete(); done_cnt = 0; busy_bad = 0; rnd_ready = rnd;
      fill_req = 1'b1; fill_color = col;
      cycle();
      chk("busy_after_req", fill_busy, 1);
      n = 0;
      while (!fill_done && n < 3000) begin
         cycle(); n++;
         if (inject && !injected && got.size() == 20) begin
            fill_req = 1'b1; fill_color = inj_col; injected = 1;
         end
      end
      chk("fill_done_seen", fill_done, 1);
      chk("busy_low_at_done", fill_busy, 0);
      check_stream("fill", fill_model(col));
      chk("fill_byte_count", got.size(), NBYTES);
      chk("busy_spans_stream", busy_bad, 0);
      if (req_at_done) begin fill_req = 1'b1; fill_color = COLOR_WHITE; end
      rnd_ready = 0;
      got.delete();
      repeat (4) cycle();
      chk("single_done_pulse", done_cnt, 1);
      if (!inject) begin
`ifdef LCD_FILL_QUEUE_EN
         chk("tail_quiet", got.size(), 0);
`else
         chk("tail_quiet", got.size(), 0);
         chk("tail_idle", fill_busy, 0);
`endif
      end
   endtask

   initial begin
      int n;
      repeat (2) cycle();
      chk_reset_vals("por");
      rst_n = 1'b1;
      run_init(1'b1);
`ifdef LCD_FILL_QUEUE_EN
      got.delete();
      wait_done("queued");
      check_stream("queued_fill", fill_model(COLOR_BLUE));
      repeat (2) cycle();
`else
      got.delete();
      repeat (10) cycle();
      chk("init_req_dropped", got.size(), 0);
      chk("init_req_no_busy", fill_busy, 0);
`endif

`ifdef LCD_FILL_QUEUE_EN
      run_fill(COLOR_RED, 1'b0, 1'b0, 16'h0000, 1'b0);
      run_fill(COLOR_WHITE, 1'b0, 1'b1, COLOR_BLUE, 1'b0);
      wait_done("latest_wins");
      check_stream("pending_fill", fill_model(COLOR_BLUE));
      repeat (2) cycle();
`else
      run_fill(COLOR_RED, 1'b0, 1'b0, 16'h0000, 1'b1);
      run_fill(COLOR_WHITE, 1'b0, 1'b1, COLOR_BLUE, 1'b0);
      chk("busy_req_dropped", got.size(), 0);
      chk("busy_req_no_busy", fill_busy, 0);
`endif
      run_fill(COLOR_GREEN, 1'b1, 1'b0, 16'h0000, 1'b0);

      got.delete(); rnd_ready = 1;
      fill_req = 1'b1; fill_color = COLOR_RED;
      n = 0; while (got.size() < 20 && n < 500) begin cycle(); n++; end
      #3 rst_n = 1'b0;
      #1 chk_reset_vals("mid_fill_reset");
      stall_prev = 0; rnd_ready = 0;
      repeat (3) cycle();
      chk_reset_vals("held_reset");
      rst_n = 1'b1;
      run_init(1'b0);
      run_fill(COLOR_BLUE, 1'b1, 1'b0, 16'h0000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_fill_ctrl.md
Name: lcd_fill_ctrl

Overview:
Sequences an SPI TFT panel (ST7789-class, RGB565) from power-up through full-screen colour fills.
- Drives the panel reset pin and runs the init command list.
- On request, emits window-set commands (CASET/RASET/RAMWR) followed by H_RES×V_RES pixels as a byte stream with a D/C flag.
- Feeds the team's byte-level SPI serializer over a valid/ready handshake; sits between test/colour-select logic and that serializer.

Parameters:
H_RES, 240, panel width in pixels
V_RES, 240, panel height in pixels
RST_CYCLES, 500000, clk cycles lcd_rst held low (10 ms), and again high before first command
WAKE_CYCLES, 6000000, clk cycles waited after SLPOUT (120 ms)

Ports:
clk_50mhz  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
fill_req  in  1  single-cycle fill request
fill_color  in  16  RGB565 fill colour, sampled with an accepted fill_req
fill_busy  out  1  high from accepted request until fill_done
fill_done  out  1  one-cycle pulse after last pixel byte accepted
init_done  out  1  high once init list complete; stays high until reset
lcd_rst  out  1  panel hardware reset, active low
tx_valid  out  1  byte valid to serializer
tx_data  out  8  byte to send
tx_dc  out  1  0 = command byte, 1 = data byte
tx_ready  in  1  serializer accepts byte when tx_valid && tx_ready

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk_50mhz.
- Reset values: lcd_rst=0, tx_valid=0, tx_data=0, tx_dc=0, init_done=0, fill_busy=0, fill_done=0; FSM=RST_LOW, all counters 0.
- Handshake: byte transfers on the cycle tx_valid && tx_ready.
  - Once tx_valid rises, tx_data/tx_dc stay stable and tx_valid stays high until accepted.
  - Next byte may be presented the cycle after acceptance (back-to-back, 1 byte/cycle max).
- FSM states and transitions:
  - RST_LOW: lcd_rst=0 for RST_CYCLES.
  - RST_WAIT: lcd_rst=1, wait RST_CYCLES.
  - SLPOUT: send cmd 0x11.
  - WAKE_WAIT: wait WAKE_CYCLES after 0x11 accepted.
  - INIT: send 0x3A(cmd), 0x55(data), 0x36(cmd), 0x00(data), 0x29(cmd), in order. After last byte accepted: init_done=1 next cycle, go IDLE.
  - IDLE: fill_req=1 latches fill_color, sets fill_busy next cycle, goes CASET.
  - CASET: 0x2A cmd, then data 0x00, 0x00, (H_RES-1)[15:8], (H_RES-1)[7:0].
  - RASET: 0x2B cmd, then the same pattern with V_RES-1.
  - RAMWR: 0x2C cmd.
  - PIXELS: H_RES×V_RES pixels, 2 data bytes each, high byte first.
  - DONE: one cycle; fill_done=1, fill_busy=0; back to IDLE.
- Pixel counter width is $clog2(H_RES*V_RES); a byte-phase bit selects high/low byte. Pixel counter terminates at H_RES*V_RES-1 with phase=1 accepted; no wrap.
- fill_req outside IDLE (during init or busy) is ignored; the latched colour is unaffected.
- fill_req in the same cycle as the DONE pulse is ignored; accepted from the first IDLE cycle.
- Delay counters run independently of tx_ready; tx_ready is don't-care when tx_valid=0.
- Reset mid-operation: immediate return to reset values; full re-init follows; partial fill is abandoned.

Optional Feature:
LCD_FILL_QUEUE_EN
- Defined: one-deep pending register.
  - fill_req arriving while not IDLE (including during init) stores its colour and sets pending; a later request overwrites it (latest wins).
  - On entering IDLE with pending set, the fill starts the next cycle without a new fill_req; pending clears.
- Undefined: non-IDLE requests are dropped as above.

Decomposition:
- Package lcd_pkg: RGB565 colour constants (WHITE FFFF, RED F800, GREEN 07E0, BLUE 001F), command opcodes (SLPOUT, COLMOD, MADCTL, DISPON, CASET, RASET, RAMWR), init-list length, FSM state enum.
- One sub-module, lcd_init_rom: combinational index → {dc, byte} lookup for the INIT list.

Test Plan:
Bench overrides: RST_CYCLES=4, WAKE_CYCLES=8, H_RES=V_RES=4; tx_ready tied 1 unless stated.
1. Release reset -> lcd_rst low 4 cycles, high 4 cycles; then 0x11(dc0); 8-cycle gap; then 3A/55/36/00/29 with dc 0,1,0,1,0; init_done rises.
2. fill_req with colour F800 after init -> exact stream 2A,00,00,00,03,2B,00,00,00,03,2C, then 16×(F8,00) all dc1. fill_busy spans the stream; one fill_done pulse; 43 bytes total.
3. tx_ready random 50% during a fill with colour 07E0 -> tx_data/tx_dc stable while stalled; no byte lost or duplicated; byte count 43.
4. fill_req with colour 001F mid-fill of FFFF, and fill_req during init -> ignored; only FFFF pixels emitted; no extra fill_done.
5. rst_n low during PIXELS -> outputs at reset values immediately; full init replays.
6. LCD_FILL_QUEUE_EN defined: fill_req with colours 07E0 then 001F during init -> single fill of 001F starts on entering IDLE; undefined build -> no fill.
